// File: rtl/uart_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_boot_loader_pkg
// Shared constants and types for the program-load path of the core.
//   LOADER_BYTE_WID / LOADER_WORD_WID : byte and word widths of the loader bus
//   LOADER_LANES                      : bytes per word
//   loader_state_t                    : boot loader FSM states
//   chk_add()                         : running mod-256 frame checksum step
// -----------------------------------------------------------------------------
package uart_boot_loader_pkg;

    localparam int LOADER_BYTE_WID = 8;
    localparam int LOADER_WORD_WID = 32;
    localparam int LOADER_LANES    = LOADER_WORD_WID / LOADER_BYTE_WID;

    typedef enum logic [2:0] {
        LEN  = 3'd0,
        DATA = 3'd1,
        CHK  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } loader_state_t;

    // Checksum is the plain byte sum of the payload, wrapping at 256.
    function automatic logic [LOADER_BYTE_WID-1:0] chk_add(
        input logic [LOADER_BYTE_WID-1:0] sum,
        input logic [LOADER_BYTE_WID-1:0] data_byte
    );
        return sum + data_byte;
    endfunction

endpackage

// File: rtl/uart_boot_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// uart_word_assembler
// Collects four little-endian bytes into one 32-bit word. The first three bytes
// are parked in a shadow register; the fourth byte is merged combinationally so
// the full word is available in the same cycle as its last byte strobe.
//   clk, rst_n  : clock, async active-low reset
//   clr         : synchronous clear of lane counter and shadow bytes
//   byte_valid  : byte_in is to be consumed this cycle
//   byte_in     : incoming byte
//   lane        : index of the lane the next byte will fill
//   word        : {byte_in, shadow bytes}; complete when word_ready is high
//   word_ready  : the current byte completes a word
// -----------------------------------------------------------------------------
module uart_word_assembler
    import uart_boot_loader_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       byte_valid,
    input  logic [LOADER_BYTE_WID-1:0] byte_in,
    output logic [1:0]                 lane,
    output logic [LOADER_WORD_WID-1:0] word,
    output logic                       word_ready
);

    localparam int SHADOW_W = LOADER_WORD_WID - LOADER_BYTE_WID;

    logic [1:0]          lane_r;
    logic [SHADOW_W-1:0] shadow_r;

    // Lane counter and storage of the three low bytes of the word in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_r   <= 2'd0;
            shadow_r <= {SHADOW_W{1'b0}};
        end else if (clr) begin
            lane_r   <= 2'd0;
            shadow_r <= {SHADOW_W{1'b0}};
        end else if (byte_valid) begin
            lane_r <= lane_r + 2'd1;
            case (lane_r)
                2'd0:    shadow_r[7:0]   <= byte_in;
                2'd1:    shadow_r[15:8]  <= byte_in;
                2'd2:    shadow_r[23:16] <= byte_in;
                default: shadow_r        <= shadow_r;   // lane 3 is merged directly
            endcase
        end else begin
            lane_r   <= lane_r;
            shadow_r <= shadow_r;
        end
    end

    assign lane       = lane_r;
    assign word       = {byte_in, shadow_r};
    assign word_ready = byte_valid && (lane_r == 2'd3);

endmodule

// File: rtl/uart_boot_loader.sv
// -----------------------------------------------------------------------------
// uart_boot_loader
// Loads a framed program image from the UART into memory port B, then releases
// the core. Frame: 4-byte LE word count N, N LE words, 1 checksum byte (sum of
// payload bytes mod 256).
//   clk, rst_n  : cpuclk, async active-low reset
//   rx_valid    : one-cycle strobe qualifying rx_byte
//   rx_byte     : received byte
//   reload      : restart loading from the frame start (wins over rx_valid)
//   uart_addr   : byte address of the last written word (ADDR_BASE after reset)
//   uart_data   : last written word
//   uart_we     : one-cycle write strobe for uart_addr/uart_data
//   uart_done   : load complete, core owns port B
//   load_err    : frame rejected, sticky until reload
//   word_cnt    : words written in the current frame
// -----------------------------------------------------------------------------
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          MAX_WORDS   = 16384,
    parameter int          TIMEOUT_CYC = 1_000_000,
    parameter int          CNT_W       = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_valid,
    input  logic [LOADER_BYTE_WID-1:0] rx_byte,
    input  logic                       reload,
    output logic [31:0]                uart_addr,
    output logic [LOADER_WORD_WID-1:0] uart_data,
    output logic                       uart_we,
    output logic                       uart_done,
    output logic                       load_err,
    output logic [CNT_W-1:0]           word_cnt
);

    localparam int                TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [31:0]       MAX_LEN  = 32'(MAX_WORDS);

    loader_state_t                state_r;
    logic [CNT_W-1:0]             len_r;
    logic [CNT_W-1:0]             word_cnt_r;
    logic [LOADER_BYTE_WID-1:0]   chk_r;
    logic [TMR_W-1:0]             tmr_r;
    logic [31:0]                  uart_addr_r;
    logic [LOADER_WORD_WID-1:0]   uart_data_r;
    logic                         uart_we_r;
    logic                         uart_done_r;
    logic                         load_err_r;

    logic                         acc_s;
    logic                         asm_valid_s;
    logic                         tmr_run_s;
    logic                         timeout_s;
    logic [1:0]                   lane_s;
    logic [LOADER_WORD_WID-1:0]   word_s;
    logic                         word_ready_s;

    uart_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (reload),
        .byte_valid (asm_valid_s),
        .byte_in    (rx_byte),
        .lane       (lane_s),
        .word       (word_s),
        .word_ready (word_ready_s)
    );

    // Byte acceptance, assembler feed and timeout qualification for this state.
    always_comb begin
        acc_s       = 1'b0;
        asm_valid_s = 1'b0;
        tmr_run_s   = 1'b0;
        case (state_r)
            LEN: begin
                acc_s       = rx_valid && !reload;
                asm_valid_s = acc_s;
                // Waiting for the host to start a frame is not a timeout.
                tmr_run_s   = (lane_s != 2'd0);
            end
            DATA: begin
                acc_s       = rx_valid && !reload;
                asm_valid_s = acc_s;
                tmr_run_s   = 1'b1;
            end
            CHK: begin
                acc_s       = rx_valid && !reload;
                asm_valid_s = 1'b0;
                tmr_run_s   = 1'b1;
            end
            default: begin
                acc_s       = 1'b0;
                asm_valid_s = 1'b0;
                tmr_run_s   = 1'b0;
            end
        endcase
        if (tmr_run_s && !acc_s && !reload) begin
            timeout_s = (tmr_r == TMR_LAST);
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Inter-byte idle timer; restarts on every accepted byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_r <= {TMR_W{1'b0}};
        end else if (reload || acc_s || !tmr_run_s) begin
            tmr_r <= {TMR_W{1'b0}};
        end else begin
            tmr_r <= tmr_r + TMR_W'(1);
        end
    end

    // Loader FSM with its checksum, word counter and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= LEN;
            len_r       <= {CNT_W{1'b0}};
            word_cnt_r  <= {CNT_W{1'b0}};
            chk_r       <= {LOADER_BYTE_WID{1'b0}};
            uart_addr_r <= ADDR_BASE;
            uart_data_r <= {LOADER_WORD_WID{1'b0}};
            uart_we_r   <= 1'b0;
            uart_done_r <= 1'b0;
            load_err_r  <= 1'b0;
        end else if (reload) begin
            state_r     <= LEN;
            word_cnt_r  <= {CNT_W{1'b0}};
            chk_r       <= {LOADER_BYTE_WID{1'b0}};
            uart_addr_r <= ADDR_BASE;
            uart_we_r   <= 1'b0;
            uart_done_r <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            uart_we_r <= 1'b0;
            case (state_r)
                LEN: begin
                    if (acc_s && word_ready_s) begin
                        if ((word_s == 32'd0) || (word_s > MAX_LEN)) begin
                            state_r    <= ERR;
                            load_err_r <= 1'b1;
                        end else begin
                            state_r    <= DATA;
                            len_r      <= word_s[CNT_W-1:0];
                            word_cnt_r <= {CNT_W{1'b0}};
                            chk_r      <= {LOADER_BYTE_WID{1'b0}};
                        end
                    end else if (timeout_s) begin
                        state_r    <= ERR;
                        load_err_r <= 1'b1;
                    end else begin
                        state_r <= LEN;
                    end
                end
                DATA: begin
                    if (acc_s) begin
                        chk_r <= chk_add(chk_r, rx_byte);
                        if (word_ready_s) begin
                            uart_we_r   <= 1'b1;
                            uart_data_r <= word_s;
                            uart_addr_r <= ADDR_BASE + (32'(word_cnt_r) << 2);
                            word_cnt_r  <= word_cnt_r + CNT_W'(1);
                            if ((word_cnt_r + CNT_W'(1)) == len_r) begin
                                state_r <= CHK;
                            end else begin
                                state_r <= DATA;
                            end
                        end else begin
                            state_r <= DATA;
                        end
                    end else if (timeout_s) begin
                        state_r    <= ERR;
                        load_err_r <= 1'b1;
                    end else begin
                        state_r <= DATA;
                    end
                end
                CHK: begin
                    if (acc_s) begin
                        if (rx_byte == chk_r) begin
                            state_r     <= DONE;
                            uart_done_r <= 1'b1;
                        end else begin
                            state_r    <= ERR;
                            load_err_r <= 1'b1;
                        end
                    end else if (timeout_s) begin
                        state_r    <= ERR;
                        load_err_r <= 1'b1;
                    end else begin
                        state_r <= CHK;
                    end
                end
                DONE: begin
                    state_r     <= DONE;
                    uart_done_r <= 1'b1;
                end
                ERR: begin
                    state_r     <= ERR;
                    load_err_r  <= 1'b1;
                    uart_done_r <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: fail safe, keep the core in reset.
                    state_r     <= ERR;
                    load_err_r  <= 1'b1;
                    uart_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign uart_addr = uart_addr_r;
    assign uart_data = uart_data_r;
    assign uart_we   = uart_we_r;
    assign uart_done = uart_done_r;
    assign load_err  = load_err_r;
    assign word_cnt  = word_cnt_r;

endmodule
